// File: rtl/morph_bbox_pkg.sv
// Shared definitions for the morphology bounding-box stage: frame geometry
// defaults, coordinate/count widths and the frame-tracking FSM encoding.
package morph_bbox_pkg;

    localparam int DEF_IMG_W   = 640;
    localparam int DEF_IMG_H   = 480;
    localparam int DEF_MIN_PIX = 64;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 19;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACTIVE    = 2'd1,
        LATCH     = 2'd2
    } state_e;

endpackage

// File: rtl/morph_bbox_if.sv
// Pixel-stream input and per-frame bounding-box result bundle.
// The master side is the morphology source plus the downstream consumer;
// the slave side is the bounding-box block itself.
interface morph_bbox_if;
    import morph_bbox_pkg::*;

    logic          cam_href;
    logic          cam_vsync;
    logic          din_val;
    logic          din;

    logic          box_valid;
    logic          box_found;
    logic [XW-1:0] x_min;
    logic [XW-1:0] x_max;
    logic [YW-1:0] y_min;
    logic [YW-1:0] y_max;
    logic [CW-1:0] pix_cnt;

    modport master (
        output cam_href, cam_vsync, din_val, din,
        input  box_valid, box_found, x_min, x_max, y_min, y_max, pix_cnt
    );

    modport slave (
        input  cam_href, cam_vsync, din_val, din,
        output box_valid, box_found, x_min, x_max, y_min, y_max, pix_cnt
    );

endinterface

// File: rtl/morph_bbox_sync_edge.sv
// Registers a sync signal once and produces single-cycle rise/fall pulses
// from the live input against its registered copy, so an edge is seen in
// the same cycle the new level arrives.
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    // One-cycle history of the sync input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/morph_bbox.sv
// Foreground bounding box and pixel count per frame from the eroded 1-bit
// pixel stream. Results are latched at each frame boundary and announced
// with a one-cycle box_valid pulse, two cycles after vsync rises.
module morph_bbox
    import morph_bbox_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int MIN_PIX = DEF_MIN_PIX
) (
    input logic         module_clk,
    input logic         module_rst_n,
    morph_bbox_if.slave bus
);

    localparam logic [XW-1:0] X_LIM   = XW'(IMG_W);
    localparam logic [XW-1:0] X_INIT  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LIM   = YW'(IMG_H);
    localparam logic [YW-1:0] Y_INIT  = YW'(IMG_H - 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_PIX);

    logic          href_rise;
    logic          href_fall;
    logic          vsync_rise;
    logic          unused_vsync_fall;

    state_e        state_q, state_d;
    logic [XW-1:0] xc_q, xc_d;
    logic [YW-1:0] yc_q, yc_d;
    logic          line_act_q, line_act_d;

    logic [XW-1:0] xmin_q, xmin_d;
    logic [XW-1:0] xmax_q, xmax_d;
    logic [YW-1:0] ymin_q, ymin_d;
    logic [YW-1:0] ymax_q, ymax_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          valid_q, valid_d;
    logic          found_q, found_d;
    logic [XW-1:0] oxmin_q, oxmin_d;
    logic [XW-1:0] oxmax_q, oxmax_d;
    logic [YW-1:0] oymin_q, oymin_d;
    logic [YW-1:0] oymax_q, oymax_d;
    logic [CW-1:0] ocnt_q, ocnt_d;

    logic          pix_hit;

    sync_edge u_href_edge (
        .clk_i  (module_clk),
        .rst_ni (module_rst_n),
        .sig_i  (bus.cam_href),
        .rise_o (href_rise),
        .fall_o (href_fall)
    );

    // The falling edge of vsync has no meaning for this block.
    sync_edge u_vsync_edge (
        .clk_i  (module_clk),
        .rst_ni (module_rst_n),
        .sig_i  (bus.cam_vsync),
        .rise_o (vsync_rise),
        .fall_o (unused_vsync_fall)
    );

    // A foreground pixel inside the active image area.
    assign pix_hit = bus.din_val & bus.din & (xc_q < X_LIM) & (yc_q < Y_LIM);

    // Pixel/line position tracking. Lines that carried no pixel strobe do
    // not advance y; x stops at IMG_W so overlong lines are ignored.
    always_comb begin
        xc_d       = xc_q;
        yc_d       = yc_q;
        line_act_d = line_act_q;

        if (href_fall) begin
            xc_d = '0;
        end else if (bus.cam_href && bus.din_val && (xc_q < X_LIM)) begin
            xc_d = xc_q + 1'b1;
        end

        if (bus.cam_href && bus.din_val) begin
            line_act_d = 1'b1;
        end else if (href_rise) begin
            line_act_d = 1'b0;
        end

        if (vsync_rise || (state_q == LATCH)) begin
            yc_d = '0;
        end else if (href_fall && line_act_q && (yc_q < Y_LIM)) begin
            yc_d = yc_q + 1'b1;
        end
    end

    // Accumulators restart from their init values outside ACTIVE; a pixel
    // arriving during LATCH is merged into the freshly started frame.
    always_comb begin
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        cnt_d  = cnt_q;

        if (state_q != ACTIVE) begin
            xmin_d = X_INIT;
            xmax_d = '0;
            ymin_d = Y_INIT;
            ymax_d = '0;
            cnt_d  = '0;
        end

        if ((state_q != WAIT_SYNC) && pix_hit) begin
            if (xc_q < xmin_d) xmin_d = xc_q;
            if (xc_q > xmax_d) xmax_d = xc_q;
            if (yc_q < ymin_d) ymin_d = yc_q;
            if (yc_q > ymax_d) ymax_d = yc_q;
            if (cnt_d != '1)   cnt_d  = cnt_d + 1'b1;
        end
    end

    // Frame FSM next state, plus the result latch performed in LATCH.
    // An empty frame reports zero coordinates rather than the init values.
    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        found_d = found_q;
        oxmin_d = oxmin_q;
        oxmax_d = oxmax_q;
        oymin_d = oymin_q;
        oymax_d = oymax_q;
        ocnt_d  = ocnt_q;

        case (state_q)
            WAIT_SYNC: if (vsync_rise) state_d = ACTIVE;
            ACTIVE:    if (vsync_rise) state_d = LATCH;
            LATCH:     state_d = ACTIVE;
            default:   state_d = WAIT_SYNC;
        endcase

        if (state_q == LATCH) begin
            valid_d = 1'b1;
            ocnt_d  = cnt_q;
            if (cnt_q == '0) begin
                found_d = 1'b0;
                oxmin_d = '0;
                oxmax_d = '0;
                oymin_d = '0;
                oymax_d = '0;
            end else begin
                found_d = (cnt_q >= CNT_MIN);
                oxmin_d = xmin_q;
                oxmax_d = xmax_q;
                oymin_d = ymin_q;
                oymax_d = ymax_q;
            end
        end
    end

    // FSM state and stream position registers.
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            state_q    <= WAIT_SYNC;
            xc_q       <= '0;
            yc_q       <= '0;
            line_act_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            xc_q       <= xc_d;
            yc_q       <= yc_d;
            line_act_q <= line_act_d;
        end
    end

    // Running per-frame accumulators.
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            xmin_q <= X_INIT;
            xmax_q <= '0;
            ymin_q <= Y_INIT;
            ymax_q <= '0;
            cnt_q  <= '0;
        end else begin
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            cnt_q  <= cnt_d;
        end
    end

    // Published results, held until the next frame boundary.
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            valid_q <= 1'b0;
            found_q <= 1'b0;
            oxmin_q <= '0;
            oxmax_q <= '0;
            oymin_q <= '0;
            oymax_q <= '0;
            ocnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            found_q <= found_d;
            oxmin_q <= oxmin_d;
            oxmax_q <= oxmax_d;
            oymin_q <= oymin_d;
            oymax_q <= oymax_d;
            ocnt_q  <= ocnt_d;
        end
    end

    assign bus.box_valid = valid_q;
    assign bus.box_found = found_q;
    assign bus.x_min     = oxmin_q;
    assign bus.x_max     = oxmax_q;
    assign bus.y_min     = oymin_q;
    assign bus.y_max     = oymax_q;
    assign bus.pix_cnt   = ocnt_q;

endmodule
